// File: rtl/insn_sequencer_pkg.sv
// Shared encodings for the instruction sequencer: opcodes, funct codes, ALU codes,
// sequencer state encoding and the latched control word.
package insn_sequencer_pkg;

  localparam int ALU_W = 4;

  localparam logic [5:0] OP_CODE_ALU  = 6'h00;
  localparam logic [5:0] OP_CODE_BEQ  = 6'h04;
  localparam logic [5:0] OP_CODE_BNE  = 6'h05;
  localparam logic [5:0] OP_CODE_ADDI = 6'h08;
  localparam logic [5:0] OP_CODE_ANDI = 6'h0C;
  localparam logic [5:0] OP_CODE_ORI  = 6'h0D;
  localparam logic [5:0] OP_CODE_LD   = 6'h23;
  localparam logic [5:0] OP_CODE_ST   = 6'h2B;

  localparam logic [5:0] FUNCT_CODE_SLL = 6'h00;
  localparam logic [5:0] FUNCT_CODE_SRL = 6'h02;
  localparam logic [5:0] FUNCT_CODE_ADD = 6'h20;
  localparam logic [5:0] FUNCT_CODE_SUB = 6'h22;
  localparam logic [5:0] FUNCT_CODE_AND = 6'h24;
  localparam logic [5:0] FUNCT_CODE_OR  = 6'h25;
  localparam logic [5:0] FUNCT_CODE_XOR = 6'h26;
  localparam logic [5:0] FUNCT_CODE_SLT = 6'h2A;

  localparam logic [ALU_W-1:0] ALU_CODE_ADD = 4'd0;
  localparam logic [ALU_W-1:0] ALU_CODE_SUB = 4'd1;
  localparam logic [ALU_W-1:0] ALU_CODE_AND = 4'd2;
  localparam logic [ALU_W-1:0] ALU_CODE_OR  = 4'd3;
  localparam logic [ALU_W-1:0] ALU_CODE_XOR = 4'd4;
  localparam logic [ALU_W-1:0] ALU_CODE_SLT = 4'd5;
  localparam logic [ALU_W-1:0] ALU_CODE_SLL = 4'd6;
  localparam logic [ALU_W-1:0] ALU_CODE_SRL = 4'd7;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd7
  } SeqState;

  typedef enum logic [2:0] {
    CLS_R   = 3'd0,
    CLS_IMM = 3'd1,
    CLS_LD  = 3'd2,
    CLS_ST  = 3'd3,
    CLS_BEQ = 3'd4,
    CLS_BNE = 3'd5
  } InsnClass;

  typedef struct packed {
    InsnClass         cls;
    logic [ALU_W-1:0] alu_code;
    logic             alu_src_b;
    logic             reg_wr_sel;
    logic             reg_wr_src;
    logic             illegal;
  } CtlWord;

endpackage

// File: rtl/insn_sequencer_decoder.sv
// Combinational op/funct decode into instruction class and datapath selects.
module insn_decoder
  import insn_sequencer_pkg::*;
(
  input  logic [5:0]       i_op,
  input  logic [5:0]       i_funct,
  output logic [2:0]       o_cls,
  output logic [ALU_W-1:0] o_alu_code,
  output logic             o_alu_src_b,
  output logic             o_reg_wr_sel,
  output logic             o_reg_wr_src,
  output logic             o_illegal
);

  always_comb begin
    o_cls        = CLS_R;
    o_alu_code   = ALU_CODE_ADD;
    o_alu_src_b  = 1'b0;
    o_reg_wr_sel = 1'b0;
    o_reg_wr_src = 1'b0;
    o_illegal    = 1'b0;
    case (i_op)
      OP_CODE_ALU: begin
        case (i_funct)
          FUNCT_CODE_ADD: o_alu_code = ALU_CODE_ADD;
          FUNCT_CODE_SUB: o_alu_code = ALU_CODE_SUB;
          FUNCT_CODE_AND: o_alu_code = ALU_CODE_AND;
          FUNCT_CODE_OR:  o_alu_code = ALU_CODE_OR;
          FUNCT_CODE_XOR: o_alu_code = ALU_CODE_XOR;
          FUNCT_CODE_SLT: o_alu_code = ALU_CODE_SLT;
          // shift amount comes from the expanded constant, not rt
          FUNCT_CODE_SLL: begin o_alu_code = ALU_CODE_SLL; o_alu_src_b = 1'b1; end
          FUNCT_CODE_SRL: begin o_alu_code = ALU_CODE_SRL; o_alu_src_b = 1'b1; end
          default:        o_illegal = 1'b1;
        endcase
      end
      OP_CODE_ADDI: begin o_cls = CLS_IMM; o_alu_code = ALU_CODE_ADD; o_alu_src_b = 1'b1; o_reg_wr_sel = 1'b1; end
      OP_CODE_ANDI: begin o_cls = CLS_IMM; o_alu_code = ALU_CODE_AND; o_alu_src_b = 1'b1; o_reg_wr_sel = 1'b1; end
      OP_CODE_ORI:  begin o_cls = CLS_IMM; o_alu_code = ALU_CODE_OR;  o_alu_src_b = 1'b1; o_reg_wr_sel = 1'b1; end
      OP_CODE_LD: begin
        o_cls = CLS_LD; o_alu_src_b = 1'b1; o_reg_wr_sel = 1'b1; o_reg_wr_src = 1'b1;
      end
      OP_CODE_ST:  begin o_cls = CLS_ST; o_alu_src_b = 1'b1; end
      OP_CODE_BEQ: begin o_cls = CLS_BEQ; o_alu_code = ALU_CODE_SUB; end
      OP_CODE_BNE: begin o_cls = CLS_BNE; o_alu_code = ALU_CODE_SUB; end
      default:     o_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/insn_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer; every output is a register loaded
// from the state being entered, so no input reaches an output combinationally.
module insn_sequencer
  import insn_sequencer_pkg::*;
#(
  parameter int MEM_WAIT_MAX = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       regEqual,
  input  logic       memReady,
  output logic       irWrEnable,
  output logic       pcIncEnable,
  output logic       pcBranchEnable,
  output logic       regWrEnable,
  output logic       regWrSel,
  output logic       regWrSrc,
  output logic       aluSrcB,
  output logic [3:0] aluCode,
  output logic       dataRdEnable,
  output logic       dataWrEnable,
  output logic [2:0] state,
  output logic       errorFlag
);

  localparam int               WAIT_W    = $clog2(MEM_WAIT_MAX + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_WAIT_MAX - 1);

  SeqState           r_state;
  logic              r_live;
  CtlWord            r_ctl;
  logic [WAIT_W-1:0] r_wait;

  SeqState          w_next;
  CtlWord           w_dec;
  CtlWord           w_ctl;
  logic             w_take;
  logic             w_alu_live;
  logic [2:0]       w_dec_cls;
  logic [ALU_W-1:0] w_dec_alu;
  logic             w_dec_srcb, w_dec_sel, w_dec_src, w_dec_ill;

  insn_decoder u_dec (
    .i_op        (op),
    .i_funct     (funct),
    .o_cls       (w_dec_cls),
    .o_alu_code  (w_dec_alu),
    .o_alu_src_b (w_dec_srcb),
    .o_reg_wr_sel(w_dec_sel),
    .o_reg_wr_src(w_dec_src),
    .o_illegal   (w_dec_ill)
  );

  assign w_dec = '{cls: InsnClass'(w_dec_cls), alu_code: w_dec_alu, alu_src_b: w_dec_srcb,
                   reg_wr_sel: w_dec_sel, reg_wr_src: w_dec_src, illegal: w_dec_ill};

  // The control word is only sampled from the inputs on the DECODE edge.
  assign w_ctl      = (r_state == S_DECODE) ? w_dec : r_ctl;
  assign w_take     = ((w_ctl.cls == CLS_BEQ) && regEqual) || ((w_ctl.cls == CLS_BNE) && !regEqual);
  assign w_alu_live = (w_next == S_EXEC) || (w_next == S_MEM) || (w_next == S_WB);
  assign state      = r_state;

  always_comb begin
    w_next = r_state;
    if (!r_live) begin
      w_next = S_FETCH;
    end else begin
      case (r_state)
        S_FETCH:  w_next = S_DECODE;
        S_DECODE: w_next = w_dec.illegal ? S_HALT : S_EXEC;
        S_EXEC: begin
          case (r_ctl.cls)
            CLS_LD, CLS_ST:   w_next = S_MEM;
            CLS_BEQ, CLS_BNE: w_next = S_FETCH;
            default:          w_next = S_WB;
          endcase
        end
        S_MEM: begin
          if (memReady)                w_next = (r_ctl.cls == CLS_LD) ? S_WB : S_FETCH;
          else if (r_wait == WAIT_LAST) w_next = S_HALT;
        end
        S_WB:    w_next = S_FETCH;
        default: w_next = S_HALT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state        <= S_FETCH;
      r_live         <= 1'b0;
      r_ctl          <= '0;
      r_wait         <= '0;
      irWrEnable     <= 1'b0;
      pcIncEnable    <= 1'b0;
      pcBranchEnable <= 1'b0;
      regWrEnable    <= 1'b0;
      regWrSel       <= 1'b0;
      regWrSrc       <= 1'b0;
      aluSrcB        <= 1'b0;
      aluCode        <= '0;
      dataRdEnable   <= 1'b0;
      dataWrEnable   <= 1'b0;
      errorFlag      <= 1'b0;
    end else begin
      r_live         <= 1'b1;
      r_state        <= w_next;
      r_ctl          <= w_ctl;
      r_wait         <= ((r_state == S_MEM) && (w_next == S_MEM)) ? r_wait + WAIT_W'(1) : '0;
      irWrEnable     <= (w_next == S_FETCH);
      pcIncEnable    <= (w_next == S_FETCH);
      pcBranchEnable <= (w_next == S_EXEC) && w_take;
      regWrEnable    <= (w_next == S_WB);
      regWrSel       <= (w_next == S_WB) && w_ctl.reg_wr_sel;
      regWrSrc       <= (w_next == S_WB) && w_ctl.reg_wr_src;
      aluSrcB        <= w_alu_live && w_ctl.alu_src_b;
      aluCode        <= w_alu_live ? w_ctl.alu_code : '0;
      dataRdEnable   <= (w_next == S_MEM) && (w_ctl.cls == CLS_LD);
      dataWrEnable   <= (w_next == S_MEM) && (w_ctl.cls == CLS_ST);
      errorFlag      <= errorFlag | (w_next == S_HALT);
    end
  end

endmodule

// File: tb/tb_insn_sequencer.sv
// Directed bench: a per-instruction cycle model built from the sequencing rules,
// checked against the DUT outputs on every cycle, plus literal spot checks.
module tb_insn_sequencer;
  import insn_sequencer_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [5:0] op = 6'h00, funct = 6'h00;
  logic       regEqual = 1'b0, memReady = 1'b1;
  logic       irWrEnable, pcIncEnable, pcBranchEnable, regWrEnable, regWrSel, regWrSrc;
  logic       aluSrcB, dataRdEnable, dataWrEnable, errorFlag;
  logic [3:0] aluCode;
  logic [2:0] state;

  always #5 clk = ~clk;

  insn_sequencer #(.MEM_WAIT_MAX(15)) dut (
    .clk(clk), .rst(rst), .op(op), .funct(funct), .regEqual(regEqual), .memReady(memReady),
    .irWrEnable(irWrEnable), .pcIncEnable(pcIncEnable), .pcBranchEnable(pcBranchEnable),
    .regWrEnable(regWrEnable), .regWrSel(regWrSel), .regWrSrc(regWrSrc), .aluSrcB(aluSrcB),
    .aluCode(aluCode), .dataRdEnable(dataRdEnable), .dataWrEnable(dataWrEnable),
    .state(state), .errorFlag(errorFlag)
  );

  typedef struct packed {
    logic [2:0] st;
    logic       ir, pci, pcb, rwe, rsel, rsrc, srcb;
    logic [3:0] alu;
    logic       drd, dwr, err;
  } out_t;

  typedef struct packed {
    out_t       o;
    logic [5:0] op, funct;
    logic       req, mrdy;
  } cyc_t;

  out_t act;
  assign act = {state, irWrEnable, pcIncEnable, pcBranchEnable, regWrEnable, regWrSel,
                regWrSrc, aluSrcB, aluCode, dataRdEnable, dataWrEnable, errorFlag};

  cyc_t seq[$];
  out_t expq[$];
  out_t e;
  int   errors = 0, checks = 0;

  task automatic chk(input string name, input logic [31:0] a, input logic [31:0] x);
    checks++;
    if (a !== x) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, a, x);
    end
  endtask

  always @(negedge clk) begin
    if (expq.size() > 0) begin
      e = expq.pop_front();
      checks++;
      if (act !== e) begin
        errors++;
        $display("FAIL cycle t=%0t: actual=%b required=%b (st ir pci pcb rwe rsel rsrc srcb alu drd dwr err)",
                 $time, act, e);
      end
    end
  end

  // Instruction class: 0 R, 1 imm, 2 LD, 3 ST, 4 BEQ, 5 BNE, -1 illegal.
  function automatic int cls_of(input logic [5:0] o, input logic [5:0] f);
    case (o)
      OP_CODE_ALU: case (f)
        FUNCT_CODE_ADD, FUNCT_CODE_SUB, FUNCT_CODE_AND, FUNCT_CODE_OR,
        FUNCT_CODE_XOR, FUNCT_CODE_SLT, FUNCT_CODE_SLL, FUNCT_CODE_SRL: return 0;
        default: return -1;
      endcase
      OP_CODE_ADDI, OP_CODE_ANDI, OP_CODE_ORI: return 1;
      OP_CODE_LD:  return 2;
      OP_CODE_ST:  return 3;
      OP_CODE_BEQ: return 4;
      OP_CODE_BNE: return 5;
      default:     return -1;
    endcase
  endfunction

  function automatic logic [3:0] alu_of(input logic [5:0] o, input logic [5:0] f);
    if (o == OP_CODE_ALU) begin
      case (f)
        FUNCT_CODE_SUB: return ALU_CODE_SUB;
        FUNCT_CODE_AND: return ALU_CODE_AND;
        FUNCT_CODE_OR:  return ALU_CODE_OR;
        FUNCT_CODE_XOR: return ALU_CODE_XOR;
        FUNCT_CODE_SLT: return ALU_CODE_SLT;
        FUNCT_CODE_SLL: return ALU_CODE_SLL;
        FUNCT_CODE_SRL: return ALU_CODE_SRL;
        default:        return ALU_CODE_ADD;
      endcase
    end
    if (o == OP_CODE_ANDI) return ALU_CODE_AND;
    if (o == OP_CODE_ORI) return ALU_CODE_OR;
    if (o == OP_CODE_BEQ || o == OP_CODE_BNE) return ALU_CODE_SUB;
    return ALU_CODE_ADD;
  endfunction

  function automatic logic srcb_of(input logic [5:0] o, input logic [5:0] f);
    int c;
    c = cls_of(o, f);
    if (c == 0) return (f == FUNCT_CODE_SLL) || (f == FUNCT_CODE_SRL);
    return (c >= 1) && (c <= 3);
  endfunction

  // Append one instruction's expected cycles. w = extra MEM wait cycles; w < 0 means no memReady ever.
  task automatic gen(input logic [5:0] o, input logic [5:0] f, input logic req, input int w);
    int   c, n;
    cyc_t y;
    c = cls_of(o, f);
    y = '0; y.op = o; y.funct = f; y.req = req; y.mrdy = 1'b1;
    y.o.st = 3'd0; y.o.ir = 1'b1; y.o.pci = 1'b1; seq.push_back(y);
    y.o = '0; y.o.st = 3'd1; seq.push_back(y);
    y.op = 6'h3F; y.funct = 6'h3F;   // inputs after DECODE must be ignored
    if (c < 0) begin
      y.o = '0; y.o.st = 3'd7; y.o.err = 1'b1;
      repeat (3) seq.push_back(y);
      return;
    end
    y.o = '0; y.o.st = 3'd2; y.o.alu = alu_of(o, f); y.o.srcb = srcb_of(o, f);
    y.o.pcb = (c == 4 && req) || (c == 5 && !req);
    seq.push_back(y);
    if (c >= 4) return;
    if (c == 2 || c == 3) begin
      n = (w < 0) ? 15 : w + 1;
      for (int i = 0; i < n; i++) begin
        y.o = '0; y.o.st = 3'd3; y.o.alu = alu_of(o, f); y.o.srcb = 1'b1;
        y.o.drd = (c == 2); y.o.dwr = (c == 3);
        y.mrdy = (w >= 0) && (i == w);
        seq.push_back(y);
      end
      y.mrdy = 1'b1;
      if (w < 0) begin
        y.o = '0; y.o.st = 3'd7; y.o.err = 1'b1;
        repeat (3) seq.push_back(y);
        return;
      end
      if (c == 3) return;
    end
    y.o = '0; y.o.st = 3'd4; y.o.alu = alu_of(o, f); y.o.srcb = srcb_of(o, f);
    y.o.rwe = 1'b1; y.o.rsel = (c != 0); y.o.rsrc = (c == 2);
    seq.push_back(y);
  endtask

  task automatic run_seq(input int n);
    for (int i = 0; i < n && seq.size() > 0; i++) begin
      cyc_t y;
      @(posedge clk); #1;
      y = seq.pop_front();
      op = y.op; funct = y.funct; regEqual = y.req; memReady = y.mrdy;
      expq.push_back(y.o);
    end
    @(negedge clk); #1;
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b0;
    @(negedge clk); #1;
    chk("reset_outputs", 32'(act), 32'd0);
    @(negedge clk); rst = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    do_reset();

    gen(OP_CODE_ALU, FUNCT_CODE_ADD, 1'b0, 0);
    chk("model_len_add", 32'(seq.size()), 32'd4);
    gen(OP_CODE_LD, 6'h00, 1'b0, 3);
    chk("model_len_ld_w3", 32'(seq.size()), 32'd12);
    chk("model_ld_wb_src", 32'(seq[11].o.rsrc), 32'd1);
    gen(OP_CODE_BEQ, 6'h00, 1'b1, 0);
    gen(OP_CODE_BNE, 6'h00, 1'b1, 0);
    chk("model_len_branches", 32'(seq.size()), 32'd18);
    chk("model_beq_taken", 32'(seq[14].o.pcb), 32'd1);
    chk("model_bne_not_taken", 32'(seq[17].o.pcb), 32'd0);
    gen(OP_CODE_ADDI, 6'h00, 1'b0, 0);
    gen(OP_CODE_ANDI, 6'h00, 1'b0, 0);
    gen(OP_CODE_ORI, 6'h00, 1'b0, 0);
    gen(OP_CODE_ST, 6'h00, 1'b0, 0);
    gen(OP_CODE_ALU, FUNCT_CODE_SLL, 1'b0, 0);
    gen(OP_CODE_ALU, FUNCT_CODE_SUB, 1'b0, 0);
    gen(OP_CODE_ALU, FUNCT_CODE_XOR, 1'b0, 0);
    gen(OP_CODE_BNE, 6'h00, 1'b0, 0);
    gen(OP_CODE_BEQ, 6'h00, 1'b0, 0);
    gen(OP_CODE_LD, 6'h00, 1'b0, 0);
    gen(OP_CODE_ST, 6'h00, 1'b0, 2);
    gen(OP_CODE_ST, 6'h00, 1'b0, 14);   // ready on the final allowed MEM cycle
    run_seq(1000);

    gen(OP_CODE_ST, 6'h00, 1'b0, -1);
    run_seq(1000);
    chk("timeout_state", 32'(state), 32'd7);
    chk("timeout_error", 32'(errorFlag), 32'd1);
    chk("timeout_no_write", 32'(dataWrEnable), 32'd0);

    do_reset();
    gen(OP_CODE_ALU, FUNCT_CODE_AND, 1'b0, 0);
    gen(6'h3F, 6'h00, 1'b0, 0);
    run_seq(1000);
    chk("illegal_op_error", 32'(errorFlag), 32'd1);
    chk("illegal_op_no_pc", 32'(pcIncEnable | pcBranchEnable), 32'd0);
    chk("illegal_op_no_reg", 32'(regWrEnable), 32'd0);

    do_reset();
    gen(OP_CODE_ST, 6'h00, 1'b0, -1);
    run_seq(4);
    @(posedge clk); #1;
    memReady = 1'b0;
    chk("st_mem2_write", 32'(dataWrEnable), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("async_rst_write_drop", 32'(dataWrEnable), 32'd0);
    chk("async_rst_state", 32'(state), 32'd0);
    seq.delete();
    @(negedge clk); rst = 1'b1;
    gen(OP_CODE_ORI, 6'h00, 1'b0, 0);
    gen(OP_CODE_ALU, 6'h3F, 1'b0, 0);
    run_seq(1000);
    chk("illegal_funct_halt", 32'(state), 32'd7);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
